// File: rtl/switch_cfg_loader_if.sv
// Valid/ready stream carrying one per-stage switch control word per beat.
interface switch_cfg_loader_if #(
    parameter int SWITCH_NUM = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SWITCH_NUM-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/switch_cfg_loader.sv
// Shadow-loads STAGE_NUM switch words in stage order, then swaps them into the active bank on the first net_idle edge.
// Swap lands one edge after the last beat at the earliest; cfg_ready is low while a full bank waits for idle.
module switch_cfg_loader #(
    parameter int SWITCH_NUM = 16,
    parameter int STAGE_NUM  = 9,
    parameter int GEN_W      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    switch_cfg_loader_if.slave                   cfg,
    input  logic                                 cfg_abort,
    input  logic                                 net_idle,
    output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] switch_set,
    output logic [$clog2(STAGE_NUM)-1:0]         cfg_ptr,
    output logic                                 cfg_swapped,
    output logic [GEN_W-1:0]                     cfg_gen
);
    localparam int                PTR_W    = $clog2(STAGE_NUM);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(STAGE_NUM - 1);

    typedef enum logic {LOAD, PEND} state_t;

    state_t                               state, state_nxt;
    logic [PTR_W-1:0]                     ptr_nxt;
    logic                                 shadow_we;
    logic                                 swap;
    logic                                 ready_nxt;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority over both a beat in LOAD and a swap in PEND.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = cfg_ptr;
        shadow_we = 1'b0;
        swap      = 1'b0;
        case (state)
            LOAD: begin
                if (cfg_abort) begin
                    ptr_nxt = '0;
                end else if (cfg.cfg_valid && cfg.cfg_ready) begin
                    shadow_we = 1'b1;
                    if (cfg_ptr == LAST_PTR) begin
                        ptr_nxt   = '0;
                        state_nxt = PEND;
                    end else begin
                        ptr_nxt = cfg_ptr + PTR_W'(1);
                    end
                end
            end
            PEND: begin
                if (cfg_abort) begin
                    state_nxt = LOAD;
                    ptr_nxt   = '0;
                end else if (net_idle) begin
                    swap      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
                ptr_nxt   = '0;
            end
        endcase
        ready_nxt = (state_nxt == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            switch_set    <= '0;
            cfg_ptr       <= '0;
            cfg_swapped   <= 1'b0;
            cfg_gen       <= '0;
            cfg.cfg_ready <= 1'b0;
        end else begin
            if (shadow_we) begin
                shadow[cfg_ptr] <= cfg.cfg_data;
            end
            if (swap) begin
                switch_set <= shadow;
                cfg_gen    <= cfg_gen + GEN_W'(1);
            end
            cfg_swapped   <= swap;
            cfg_ptr       <= ptr_nxt;
            cfg.cfg_ready <= ready_nxt;
        end
    end
endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed bench for switch_cfg_loader: reset, load/swap, hold, abort, races, generation wrap, async reset.
module tb_switch_cfg_loader;
    localparam int SN = 16;
    localparam int ST = 9;
    localparam int GW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_abort = 1'b0;
    logic                  net_idle = 1'b0;
    logic [ST-1:0][SN-1:0] switch_set;
    logic [3:0]            cfg_ptr;
    logic                  cfg_swapped;
    logic [GW-1:0]         cfg_gen;

    logic [ST-1:0][SN-1:0] exp_set;
    logic [ST-1:0][SN-1:0] words;
    logic [GW-1:0]         exp_gen;
    int                    total = 0;
    int                    bad = 0;

    switch_cfg_loader_if #(.SWITCH_NUM(SN)) bus ();

    switch_cfg_loader #(.SWITCH_NUM(SN), .STAGE_NUM(ST), .GEN_W(GW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (bus),
        .cfg_abort   (cfg_abort),
        .net_idle    (net_idle),
        .switch_set  (switch_set),
        .cfg_ptr     (cfg_ptr),
        .cfg_swapped (cfg_swapped),
        .cfg_gen     (cfg_gen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat until an edge where ready was high, bounded.
    task automatic send(input logic [SN-1:0] d);
        logic r;
        logic done;
        done = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        for (int n = 0; n < 40 && !done; n++) begin
            r = bus.cfg_ready;
            step();
            if (r) done = 1'b1;
        end
        bus.cfg_valid = 1'b0;
        chk("beat_accepted", 144'(done), 144'(1'b1));
    endtask

    task automatic load_all(input logic [ST-1:0][SN-1:0] w, input int max_gap);
        for (int k = 0; k < ST; k++) begin
            repeat ($urandom_range(max_gap)) step();
            send(w[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        exp_set = '0;
        exp_gen = '0;

        // Reset and registered ready
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 144'(bus.cfg_ready), 144'(1'b0));
        chk("rst_set", switch_set, 144'(0));
        chk("rst_gen", 144'(cfg_gen), 144'(0));
        chk("rst_ptr", 144'(cfg_ptr), 144'(0));
        chk("rst_swapped", 144'(cfg_swapped), 144'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 144'(bus.cfg_ready), 144'(1'b0));
        step();
        chk("rel_ready_after_edge", 144'(bus.cfg_ready), 144'(1'b1));

        // Full load with network idle
        net_idle = 1'b1;
        for (int k = 0; k < ST; k++) words[k] = 16'h0001 << k;
        load_all(words, 0);
        chk("full_pend_ready", 144'(bus.cfg_ready), 144'(1'b0));
        chk("full_pend_swapped", 144'(cfg_swapped), 144'(0));
        chk("full_pend_set", switch_set, exp_set);
        step();
        exp_set = words;
        exp_gen = exp_gen + 4'd1;
        chk("full_swapped", 144'(cfg_swapped), 144'(1));
        chk("full_set", switch_set, exp_set);
        chk("full_gen", 144'(cfg_gen), 144'(exp_gen));
        chk("full_ready", 144'(bus.cfg_ready), 144'(1));
        step();
        chk("full_swap_pulse_end", 144'(cfg_swapped), 144'(0));

        // Hold while network busy, stray beats ignored
        net_idle = 1'b0;
        for (int k = 0; k < ST; k++) words[k] = 16'h3000 | 16'(k);
        load_all(words, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'hDEAD;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("hold_ready", 144'(bus.cfg_ready), 144'(0));
            chk("hold_set", switch_set, exp_set);
        end
        bus.cfg_valid = 1'b0;
        chk("hold_ptr", 144'(cfg_ptr), 144'(0));
        net_idle = 1'b1;
        step();
        exp_set = words;
        exp_gen = exp_gen + 4'd1;
        chk("hold_swapped", 144'(cfg_swapped), 144'(1));
        chk("hold_set_new", switch_set, exp_set);
        chk("hold_gen", 144'(cfg_gen), 144'(exp_gen));

        // Abort partial load, then reload
        for (int k = 0; k < 5; k++) send(16'hFFFF);
        chk("abort_ptr_before", 144'(cfg_ptr), 144'(5));
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("abort_ptr", 144'(cfg_ptr), 144'(0));
        chk("abort_swapped", 144'(cfg_swapped), 144'(0));
        chk("abort_set_kept", switch_set, exp_set);
        for (int k = 0; k < ST; k++) words[k] = 16'hA5A5;
        load_all(words, 0);
        step();
        exp_set = words;
        exp_gen = exp_gen + 4'd1;
        chk("abort_reload_set", switch_set, exp_set);
        chk("abort_reload_gen", 144'(cfg_gen), 144'(exp_gen));

        // Abort coincident with net_idle in PEND
        net_idle = 1'b0;
        for (int k = 0; k < ST; k++) words[k] = 16'h00C3 ^ 16'(k);
        load_all(words, 0);
        cfg_abort = 1'b1;
        net_idle  = 1'b1;
        step();
        cfg_abort = 1'b0;
        net_idle  = 1'b0;
        chk("race_idle_swapped", 144'(cfg_swapped), 144'(0));
        chk("race_idle_gen", 144'(cfg_gen), 144'(exp_gen));
        chk("race_idle_set", switch_set, exp_set);
        chk("race_idle_ready", 144'(bus.cfg_ready), 144'(1));
        step();
        chk("race_idle_no_late_swap", 144'(cfg_swapped), 144'(0));

        // Abort coincident with a beat
        for (int k = 0; k < 3; k++) send(16'h1111);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'hBEEF;
        cfg_abort     = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        cfg_abort     = 1'b0;
        chk("race_beat_ptr", 144'(cfg_ptr), 144'(0));
        net_idle = 1'b1;
        for (int k = 0; k < ST; k++) words[k] = 16'h0111 * 16'(k + 1);
        load_all(words, 0);
        step();
        exp_set = words;
        exp_gen = exp_gen + 4'd1;
        chk("race_beat_set", switch_set, exp_set);
        chk("race_beat_gen", 144'(cfg_gen), 144'(exp_gen));

        // Sixteen loads with gaps; generation wraps 15 -> 0
        for (int l = 0; l < 16; l++) begin
            for (int k = 0; k < ST; k++) words[k] = 16'($urandom);
            load_all(words, 3);
            step();
            exp_set = words;
            exp_gen = exp_gen + 4'd1;
            chk("wrap_swapped", 144'(cfg_swapped), 144'(1));
            chk("wrap_set", switch_set, exp_set);
            chk("wrap_gen", 144'(cfg_gen), 144'(exp_gen));
            if (exp_gen == 4'd0) chk("wrap_gen_zero", 144'(cfg_gen), 144'(0));
        end

        // Asynchronous reset mid-load
        for (int k = 0; k < 4; k++) send(16'h7E7E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_set", switch_set, 144'(0));
        chk("arst_gen", 144'(cfg_gen), 144'(0));
        chk("arst_ptr", 144'(cfg_ptr), 144'(0));
        chk("arst_ready", 144'(bus.cfg_ready), 144'(0));
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_rel_ready", 144'(bus.cfg_ready), 144'(0));
        step();
        chk("arst_rel_ready_up", 144'(bus.cfg_ready), 144'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
